// File: rtl/sd_cmd_host.sv
// SD-bus host command engine: sdclk generation, 48-bit command TX with CRC7, R48/R136 capture.
// Optional `SD_INIT_CLOCKS_EN: hold busy for 80 power-up sdclk cycles after reset.
module sd_cmd_host #(
  parameter int unsigned CLK_DIV     = 1,
  parameter int unsigned RSP_TIMEOUT = 64,
  parameter int unsigned NCC_GAP     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic [5:0]   req_cmd,
  input  logic [31:0]  req_arg,
  input  logic [1:0]   req_rsp_type,
  output logic         busy,
  output logic         done,
  output logic         rsp_timeout,
  output logic         rsp_crc_err,
  output logic [135:0] rsp,
  output logic         sdclk,
  output logic         sdcmdoe,
  output logic         sdcmdout,
  input  logic         sdcmdin
);

  typedef enum logic [2:0] {
    StIdle, StInit, StSend, StWait, StRecv, StCheck, StGap
  } state_e;

  localparam int unsigned InitClks = 80;
`ifdef SD_INIT_CLOCKS_EN
  localparam state_e ResetState = StInit;
`else
  localparam state_e ResetState = StIdle;
`endif

  // Leading zeros leave a zero-initialised CRC7 unchanged, so short messages are left-padded.
  function automatic logic [6:0] crc7(input logic [119:0] data);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  state_e         state_q, state_d;
  logic [7:0]     div_q;
  logic           sdclk_q;
  logic [15:0]    cnt_q, cnt_d, cnt_inc;
  logic [47:0]    frame_q, frame_d;
  logic [1:0]     rsp_type_q, rsp_type_d;
  logic [135:0]   rsp_q, rsp_d;
  logic           oe_q, oe_d, out_q, out_d, done_q, done_d;
  logic           tmo_q, tmo_d, crc_err_q, crc_err_d;
  logic           tick, rise_tick, fall_tick;
  logic [39:0]    cmd_body;
  logic [6:0]     cmd_crc, r48_crc, r136_crc;
  logic [15:0]    rsp_bits;

  assign tick      = (div_q == 8'(CLK_DIV));
  assign rise_tick = tick & ~sdclk_q;
  assign fall_tick = tick & sdclk_q;
  assign cnt_inc   = cnt_q + 16'd1;
  assign cmd_body  = {2'b01, req_cmd, req_arg};
  assign cmd_crc   = crc7({80'd0, cmd_body});
  assign r48_crc   = crc7({80'd0, rsp_q[47:8]});
  assign r136_crc  = crc7(rsp_q[127:8]);
  assign rsp_bits  = (rsp_type_q == 2'd2) ? 16'd136 : 16'd48;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= 8'd0;
      sdclk_q <= 1'b0;
    end else if (tick) begin
      div_q   <= 8'd0;
      sdclk_q <= ~sdclk_q;
    end else begin
      div_q   <= div_q + 8'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    rsp_type_d = rsp_type_q;
    rsp_d      = rsp_q;
    oe_d       = oe_q;
    out_d      = out_q;
    done_d     = 1'b0;
    tmo_d      = tmo_q;
    crc_err_d  = crc_err_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          frame_d    = {cmd_body, cmd_crc, 1'b1};
          rsp_type_d = req_rsp_type;
          rsp_d      = '0;
          tmo_d      = 1'b0;
          crc_err_d  = 1'b0;
          cnt_d      = 16'd0;
          state_d    = StSend;
        end
      end
      StInit: begin
        if (rise_tick) begin
          if (cnt_inc >= 16'(InitClks)) begin
            cnt_d   = 16'd0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StSend: begin
        if (fall_tick) begin
          if (cnt_q == 16'd48) begin
            oe_d    = 1'b0;
            out_d   = 1'b1;
            cnt_d   = 16'd0;
            state_d = (rsp_type_q == 2'd0) ? StGap : StWait;
          end else begin
            oe_d    = 1'b1;
            out_d   = frame_q[47];
            frame_d = {frame_q[46:0], 1'b1};
            cnt_d   = cnt_inc;
          end
        end
      end
      StWait: begin
        // A start bit on the final counted edge still wins over the timeout.
        if (rise_tick) begin
          if (!sdcmdin) begin
            rsp_d   = {rsp_q[134:0], 1'b0};
            cnt_d   = 16'd1;
            state_d = StRecv;
          end else if (cnt_inc >= 16'(RSP_TIMEOUT)) begin
            tmo_d   = 1'b1;
            cnt_d   = 16'd0;
            state_d = StGap;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StRecv: begin
        if (rise_tick) begin
          rsp_d = {rsp_q[134:0], sdcmdin};
          if (cnt_inc == rsp_bits) begin
            cnt_d   = 16'd0;
            state_d = StCheck;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StCheck: begin
        unique case (rsp_type_q)
          2'd1:    crc_err_d = (r48_crc != rsp_q[7:1]) | ~rsp_q[0];
          2'd2:    crc_err_d = (r136_crc != rsp_q[7:1]) | ~rsp_q[0];
          default: crc_err_d = ~rsp_q[0];
        endcase
        state_d = StGap;
      end
      StGap: begin
        if (rise_tick) begin
          if (cnt_inc >= 16'(NCC_GAP)) begin
            cnt_d   = 16'd0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ResetState;
      cnt_q      <= 16'd0;
      frame_q    <= 48'd0;
      rsp_type_q <= 2'd0;
      rsp_q      <= '0;
      oe_q       <= 1'b0;
      out_q      <= 1'b1;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      crc_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      rsp_type_q <= rsp_type_d;
      rsp_q      <= rsp_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      crc_err_q  <= crc_err_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign rsp_timeout = tmo_q;
  assign rsp_crc_err = crc_err_q;
  assign rsp         = rsp_q;
  assign sdclk       = sdclk_q;
  assign sdcmdoe     = oe_q;
  assign sdcmdout    = out_q;

endmodule

// File: tb/tb_sd_cmd_host.sv
// Self-checking bench for sd_cmd_host: directed command/response vectors against a small card model.
module tb_sd_cmd_host;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0;
  logic [5:0]   req_cmd = 6'd0;
  logic [31:0]  req_arg = 32'd0;
  logic [1:0]   req_rsp_type = 2'd0;
  logic         busy, done, rsp_timeout, rsp_crc_err, sdclk, sdcmdoe, sdcmdout, sdcmdin;
  logic [135:0] rsp;
  logic         card_oe = 1'b0;
  logic         card_out = 1'b1;

  logic         d0_busy, d0_done, d0_to, d0_crc, d0_sdclk, d0_oe, d0_out;
  logic         d3_busy, d3_done, d3_to, d3_crc, d3_sdclk, d3_oe, d3_out;
  logic [135:0] d0_rsp, d3_rsp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Open-drain style CMD line with pull-up.
  assign sdcmdin = sdcmdoe ? sdcmdout : (card_oe ? card_out : 1'b1);

  sd_cmd_host #(.CLK_DIV(1), .RSP_TIMEOUT(64), .NCC_GAP(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_cmd(req_cmd), .req_arg(req_arg),
    .req_rsp_type(req_rsp_type), .busy(busy), .done(done), .rsp_timeout(rsp_timeout),
    .rsp_crc_err(rsp_crc_err), .rsp(rsp), .sdclk(sdclk), .sdcmdoe(sdcmdoe),
    .sdcmdout(sdcmdout), .sdcmdin(sdcmdin)
  );

  sd_cmd_host #(.CLK_DIV(0)) u_div0 (
    .clk(clk), .rst_n(rst_n), .req(1'b0), .req_cmd(6'd0), .req_arg(32'd0),
    .req_rsp_type(2'd0), .busy(d0_busy), .done(d0_done), .rsp_timeout(d0_to),
    .rsp_crc_err(d0_crc), .rsp(d0_rsp), .sdclk(d0_sdclk), .sdcmdoe(d0_oe),
    .sdcmdout(d0_out), .sdcmdin(1'b1)
  );

  sd_cmd_host #(.CLK_DIV(3)) u_div3 (
    .clk(clk), .rst_n(rst_n), .req(1'b0), .req_cmd(6'd0), .req_arg(32'd0),
    .req_rsp_type(2'd0), .busy(d3_busy), .done(d3_done), .rsp_timeout(d3_to),
    .rsp_crc_err(d3_crc), .rsp(d3_rsp), .sdclk(d3_sdclk), .sdcmdoe(d3_oe),
    .sdcmdout(d3_out), .sdcmdin(1'b1)
  );

  // Card-side capture of the command frame and sdclk bookkeeping.
  logic [47:0] cap_frame = 48'd0;
  int cap_n = 0;
  int rise_cnt = 0;
  int oe_rise_mark = 0;
  int oe_fall_mark = 0;
  int done_cnt = 0;
  time m_last = 0, m_prev = 0, d0_last = 0, d0_prev = 0, d3_last = 0, d3_prev = 0;

  always @(posedge sdclk) begin
    rise_cnt <= rise_cnt + 1;
    if (sdcmdoe) begin
      cap_frame <= {cap_frame[46:0], sdcmdout};
      cap_n     <= cap_n + 1;
    end
  end
  always @(posedge sdcmdoe) oe_rise_mark <= rise_cnt;
  always @(negedge sdcmdoe) oe_fall_mark <= rise_cnt;
  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  always @(posedge sdclk)   begin m_prev  <= m_last;  m_last  <= $time; end
  always @(posedge d0_sdclk) begin d0_prev <= d0_last; d0_last <= $time; end
  always @(posedge d3_sdclk) begin d3_prev <= d3_last; d3_last <= $time; end

  // CMD may only move on the clk edge that takes sdclk from 1 to 0 (reset edges excluded).
  logic rst_at_edge = 1'b0;
  logic prev_oe = 1'b0, prev_out = 1'b1, prev_sclk = 1'b0;
  int edge_changes = 0;
  int edge_bad = 0;
  always @(posedge clk) rst_at_edge <= rst_n;
  always @(negedge clk) begin
    if (rst_at_edge && ((sdcmdoe !== prev_oe) || (sdcmdout !== prev_out))) begin
      edge_changes <= edge_changes + 1;
      if (!(prev_sclk === 1'b1 && sdclk === 1'b0)) edge_bad <= edge_bad + 1;
    end
    prev_oe   <= sdcmdoe;
    prev_out  <= sdcmdout;
    prev_sclk <= sdclk;
  end

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Augmented long division by 0x89, a different formulation from the shift-register form.
  function automatic logic [6:0] tb_crc(input logic [127:0] msg, input int n);
    logic [7:0] r;
    r = 8'd0;
    for (int i = n - 1; i >= 0; i--) begin
      r = {r[6:0], msg[i]};
      if (r[7]) r = r ^ 8'h89;
    end
    for (int i = 0; i < 7; i++) begin
      r = {r[6:0], 1'b0};
      if (r[7]) r = r ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] c, input logic [31:0] a);
    logic [39:0] body;
    body = {2'b01, c, a};
    return {body, tb_crc({88'd0, body}, 40), 1'b1};
  endfunction

  task automatic issue(input logic [5:0] c, input logic [31:0] a, input logic [1:0] t,
                       input string name);
    @(negedge clk);
    req = 1'b1; req_cmd = c; req_arg = a; req_rsp_type = t;
    @(negedge clk);
    req = 1'b0;
    chk({name, "_busy_after_accept"}, busy, 1'b1);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_bits(input int base, input int n);
    for (int i = 0; i < 2000 && (cap_n - base) < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic card_reply(input logic [135:0] d, input int n, input int base);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(posedge clk);
      #1;
      if ((cap_n - base) == 48 && !sdcmdoe) seen = 1'b1;
    end
    if (seen) begin
      repeat (2) @(negedge sdclk);
      for (int b = n - 1; b >= 0; b--) begin
        @(negedge sdclk);
        card_oe  = 1'b1;
        card_out = d[b];
      end
      @(negedge sdclk);
      card_oe  = 1'b0;
      card_out = 1'b1;
    end
  endtask

  typedef struct {
    logic [5:0]   cmd;
    logic [31:0]  arg;
    logic [1:0]   typ;
    bit           reply;
    logic [135:0] rdata;
    int           rbits;
    logic [47:0]  exp_frame;
    logic [135:0] exp_rsp;
    logic         exp_to;
    logic         exp_crc;
    int           exp_gap;   // sdclk rises from CMD release to done, -1 = skip
    int           exp_span;  // sdclk rises from CMD enable to done, -1 = skip
  } vec_t;

  vec_t vecs[10];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [119:0] cid;
    logic [135:0] r2_good, r2_bad;
    int           base, dc;
    bit           ok;

    cid     = 120'h035344534431364780123456780142;
    r2_good = {8'h3F, cid, tb_crc({8'h00, cid}, 120), 1'b1};
    r2_bad  = r2_good ^ (136'd1 << 40);

    vecs[0] = '{6'd0,  32'h0,        2'd0, 1'b0, 136'd0, 0,
                48'h400000000095, 136'd0, 1'b0, 1'b0, 8, 56};
    vecs[1] = '{6'd8,  32'h1AA,      2'd1, 1'b1, 136'h08000001AA13, 48,
                48'h48000001AA87, 136'h08000001AA13, 1'b0, 1'b0, -1, -1};
    vecs[2] = '{6'd8,  32'h1AA,      2'd1, 1'b1, 136'h08000001AA12, 48,
                48'h48000001AA87, 136'h08000001AA12, 1'b0, 1'b1, -1, -1};
    vecs[3] = '{6'd8,  32'h1AA,      2'd1, 1'b1, 136'h08000001AA15, 48,
                48'h48000001AA87, 136'h08000001AA15, 1'b0, 1'b1, -1, -1};
    vecs[4] = '{6'd8,  32'h1AA,      2'd1, 1'b0, 136'd0, 0,
                48'h48000001AA87, 136'd0, 1'b1, 1'b0, 72, -1};
    vecs[5] = '{6'd2,  32'h0,        2'd2, 1'b1, r2_good, 136,
                48'h42000000004D, r2_good, 1'b0, 1'b0, -1, -1};
    vecs[6] = '{6'd2,  32'h0,        2'd2, 1'b1, r2_bad, 136,
                48'h42000000004D, r2_bad, 1'b0, 1'b1, -1, -1};
    vecs[7] = '{6'd41, 32'h40300000, 2'd3, 1'b1, 136'h3F80FF8000FF, 48,
                mk_frame(6'd41, 32'h40300000), 136'h3F80FF8000FF, 1'b0, 1'b0, -1, -1};
    vecs[8] = '{6'd41, 32'h40300000, 2'd3, 1'b1, 136'h3F80FF8000FE, 48,
                mk_frame(6'd41, 32'h40300000), 136'h3F80FF8000FE, 1'b0, 1'b1, -1, -1};
    vecs[9] = '{6'd17, 32'h12345678, 2'd0, 1'b0, 136'd0, 0,
                mk_frame(6'd17, 32'h12345678), 136'd0, 1'b0, 1'b0, 8, 56};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sdclk", sdclk, 1'b0);
    chk("rst_oe", sdcmdoe, 1'b0);
    chk("rst_out", sdcmdout, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_flags", {rsp_timeout, rsp_crc_err}, 2'b00);
    chk("rst_rsp", rsp, 136'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      base = cap_n;
      issue(vecs[i].cmd, vecs[i].arg, vecs[i].typ, $sformatf("v%0d", i));
      fork
        begin
          if (vecs[i].reply) card_reply(vecs[i].rdata, vecs[i].rbits, base);
        end
        wait_done(ok);
      join
      chk($sformatf("v%0d_done_seen", i), ok, 1'b1);
      chk($sformatf("v%0d_busy_at_done", i), busy, 1'b0);
      if (vecs[i].exp_gap >= 0)
        chk($sformatf("v%0d_release_to_done", i), rise_cnt - oe_fall_mark, vecs[i].exp_gap);
      if (vecs[i].exp_span >= 0)
        chk($sformatf("v%0d_enable_to_done", i), rise_cnt - oe_rise_mark, vecs[i].exp_span);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done, 1'b0);
      chk($sformatf("v%0d_bits_sent", i), cap_n - base, 48);
      chk($sformatf("v%0d_frame", i), cap_frame, vecs[i].exp_frame);
      chk($sformatf("v%0d_rsp", i), rsp, vecs[i].exp_rsp);
      chk($sformatf("v%0d_timeout", i), rsp_timeout, vecs[i].exp_to);
      chk($sformatf("v%0d_crc_err", i), rsp_crc_err, vecs[i].exp_crc);
    end

    // req while busy is dropped and does not disturb the frame in flight
    base = cap_n;
    dc   = done_cnt;
    issue(6'd0, 32'h0, 2'd0, "ign");
    wait_bits(base, 10);
    @(negedge clk);
    req = 1'b1; req_cmd = 6'd55; req_arg = 32'hFFFFFFFF; req_rsp_type = 2'd1;
    @(negedge clk);
    req = 1'b0;
    wait_done(ok);
    chk("ign_done_seen", ok, 1'b1);
    chk("ign_frame", cap_frame, 48'h400000000095);
    repeat (300) @(negedge clk);
    chk("ign_single_done", done_cnt - dc, 1);
    chk("ign_no_second_frame", cap_n - base, 48);
    chk("ign_idle", busy, 1'b0);

    // Reset in the middle of SEND aborts with no done pulse
    base = cap_n;
    issue(6'd17, 32'hA5A5A5A5, 2'd1, "abort");
    wait_bits(base, 20);
    @(negedge clk);
    rst_n = 1'b0;
    dc    = done_cnt;
    @(negedge clk);
    chk("abort_oe", sdcmdoe, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_out", sdcmdout, 1'b1);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("abort_no_done", done_cnt - dc, 0);
    chk("abort_stays_idle", {busy, sdcmdoe}, 2'b00);

    // sdclk period in clk cycles for three divider settings
    chk("period_div1", (m_last - m_prev) / 10, 4);
    chk("period_div0", (d0_last - d0_prev) / 10, 2);
    chk("period_div3", (d3_last - d3_prev) / 10, 8);

    chk("cmd_edges_seen", edge_changes != 0, 1'b1);
    chk("cmd_edges_on_fall_only", edge_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_cmd_host.md
Name: sd_cmd_host

Overview:
SD-bus host-side command engine: the initiator counterpart to the SDFake card-side responder.
- Generates SD clock; serialises 48-bit commands with CRC7 onto CMD.
- Captures and CRC-checks 48-bit or 136-bit responses; reports timeout.
- Sits between a local controller (e.g. card-init FSM) and the sdclk/sdcmd pins; lets the FakeSDcard example be exercised board-to-board.

Parameters:
CLK_DIV, 1, sdclk half-period in clk cycles minus 1 (sdclk = clk / (2*(CLK_DIV+1))); range 0..255
RSP_TIMEOUT, 64, max sdclk rising edges waited for response start bit
NCC_GAP, 8, idle sdclk cycles (CMD released high) after each transaction before done

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req  in  1  start command; accepted only when busy=0
req_cmd  in  6  command index
req_arg  in  32  command argument
req_rsp_type  in  2  0=none, 1=R48 with CRC check, 2=R136 (R2), 3=R48 no CRC check (R3)
busy  out  1  transaction in progress
done  out  1  one-clk pulse at end of transaction
rsp_timeout  out  1  no start bit within RSP_TIMEOUT; valid at done
rsp_crc_err  out  1  response CRC7 or end-bit mismatch; valid at done
rsp  out  136  raw response bits, right-aligned; R48 in rsp[47:0], upper bits 0
sdclk  out  1  SD clock
sdcmdoe  out  1  CMD output enable
sdcmdout  out  1  CMD driven value
sdcmdin  in  1  CMD sampled value

Behaviour:
Reset:
- Synchronous, active-low, one clock, one reset. Reset values: sdclk=0, sdcmdoe=0, sdcmdout=1, busy=0, done=0, rsp_timeout=0, rsp_crc_err=0, rsp=0, state IDLE, divider=0.
- Asserting reset mid-transaction aborts immediately; next cycle CMD is released (oe=0); no done pulse.

Clocking:
- Divider counts 0..CLK_DIV; on wrap sdclk toggles. sdclk free-runs whenever out of reset.
- rise_tick = cycle sdclk toggles 0->1; fall_tick = 1->0.
- Host changes sdcmdout/sdcmdoe only on fall_tick; samples sdcmdin only on rise_tick.

Accept:
- req && !busy in IDLE -> busy=1 next cycle.
- Frame latched = {0,1,req_cmd,req_arg,crc7,1}.
- rsp_timeout, rsp_crc_err, rsp cleared.
- req while busy is ignored; no queue.

CRC7:
- Polynomial x^7+x^3+1, init 0, MSB first.
- Command: over frame bits 47..8.
- R48 type 1: computed over rsp[47:8] must equal rsp[7:1].
- R2: computed over rsp[127:8] must equal rsp[7:1].
- All types: end bit rsp[0] must be 1, else rsp_crc_err=1.

FSM:
- IDLE -> SEND on accept.
- SEND: first fall_tick sets oe=1 and drives bit 47; one bit per fall_tick through bit 0 (48 bits). On the fall_tick after bit 0: oe=0. Go to WAIT if rsp_type!=0, else GAP.
- WAIT: each rise_tick increments timeout count.
  - sdcmdin=0 sampled -> store start bit, go to RECV.
  - Count reaches RSP_TIMEOUT -> rsp_timeout=1, go to GAP.
- RECV: shift sdcmdin on rise_tick until 48 (types 1/3) or 136 (type 2) bits total, then CHECK.
- CHECK: one clk; compute rsp_crc_err (type 3 checks end bit only); go to GAP.
- GAP: NCC_GAP rise_ticks with oe=0, then DONE.
- DONE: done=1 for one clk, busy=0, back to IDLE. Flags and rsp hold until next accept.

Timing and boundaries:
- Start bit sampled on the same rise_tick the timeout count reaches RSP_TIMEOUT: start bit wins.
- Bits shifted MSB first; rsp not updated after CHECK.

Optional Feature:
Macro SD_INIT_CLOCKS_EN.
- Defined: after reset release, busy=1 with oe=0 for 80 sdclk rising edges (card power-up, >=74 required); req ignored; then IDLE with no done pulse.
- Undefined: IDLE immediately after reset.

Test Plan:
- CMD0, arg 0, type 0 -> CMD carries 0x400000000095 MSB first. done after 48+NCC_GAP sdclk cycles; flags 0.
- CMD8, arg 0x1AA, type 1 -> frame 0x48000001AA87. Card model replies 0x08000001AA13 after 2 cycles -> rsp[47:0]=0x08000001AA13, crc_err=0, timeout=0.
- Same as above, reply last byte 0x12 -> rsp_crc_err=1. Separately, no reply -> rsp_timeout=1 after exactly 64 rising edges, rsp=0.
- CMD2, type 2; model sends 136-bit R2 with valid internal CRC7 -> rsp[135:0] matches, crc_err=0.
- Reset asserted at bit 20 of SEND -> oe=0 and busy=0 next clk, no done. req pulsed while busy -> ignored; frame unchanged.
- CLK_DIV=0 and CLK_DIV=3 -> sdclk period 2 and 8 clk. CMD transitions only on falling edges.
